cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//   Drives the Common Data Bus broadcast (BCEN/BClabel/BCdata) consumed by every reservation station.
//   Collects completed results (station label + value) from N_SRC functional units.
//   Buffers each unit's results in a small per-source FIFO.
//   Grants the bus round-robin, one broadcast per cycle, so no result is lost when units finish together.
// PARAMETERS
//   N_SRC    3   number of result sources (functional units)
//   DEPTH    2   entries per source FIFO (>=1)
//   LABEL_W  5   station label width; label 0 is reserved ("no dependency")
//   DATA_W   32  result data width
// PORTS
//   clk             input   1                clock, all state updates on posedge
//   nRST            input   1                reset, asynchronous, active-low
//   flush           input   1                sync clear of all FIFOs (mispredict/abort)
//   src_valid       input   N_SRC            source i presents a result
//   src_label       input   N_SRC*LABEL_W    source i label at [i*LABEL_W +: LABEL_W]
//   src_data        input   N_SRC*DATA_W     source i data at [i*DATA_W +: DATA_W]
//   src_ready       output  N_SRC            FIFO i can accept this cycle
//   BCEN            output  1                broadcast valid, registered
//   BClabel         output  LABEL_W          broadcast label, registered
//   BCdata          output  DATA_W           broadcast value, registered
//   BCsrc           output  2                index of granted source, registered (width covers N_SRC<=4)
//   err_zero_label  output  1                sticky: a label-0 result was offered
// BEHAVIOUR
// - Reset (nRST=0, async):
//   - FIFOs emptied.
//   - BCEN=0, BClabel=0, BCdata=0, BCsrc=0, err_zero_label=0.
//   - RR pointer=N_SRC-1, so source 0 has first priority.
// - Handshake:
//   - src_ready[i] = (count[i] < DEPTH), decoded from registered count only.
//   - Push on posedge when src_valid[i] & src_ready[i].
//   - Source holds label/data until accepted.
// - Label 0: a valid & ready offer with label 0 is consumed but not stored; err_zero_label<=1 (sticky).
// - Arbitration each posedge:
//   - Candidates = FIFOs non-empty before this edge.
//   - Winner = first candidate at (ptr+1), (ptr+2), ... mod N_SRC.
//   - Pop winner's head; BCEN<=1, BClabel/BCdata<=head, BCsrc<=winner, ptr<=winner.
//   - No candidate: BCEN<=0, label/data/src hold, ptr holds.
// - Latency: push at edge k -> earliest BCEN=1 with that result after edge k+1 (no bypass).
// - Each BCEN pulse lasts exactly one cycle per result; no repeats.
// - Simultaneous push+pop on the same FIFO: both occur, count unchanged; FIFO order preserved.
// - Full FIFO: src_ready=0 even if popped that same cycle; space visible next cycle.
// - Count/pointers wrap modulo DEPTH; count never exceeds DEPTH or underflows.
// - flush=1 at posedge:
//   - All FIFOs emptied; pushes that cycle dropped; BCEN<=0; ptr<=N_SRC-1.
//   - err_zero_label unchanged.
//   - flush overrides push and grant.
// - Outputs come from registers only; no combinational path from src_* to BC*.
// TESTING
//   1. Reset: hold nRST=0 -> BCEN=0, BClabel=0, BCdata=0, src_ready=3'b111, err_zero_label=0.
//   2. Single result: src0 label 1, data 32'h11 accepted at edge 1
//      -> after edge 2 BCEN=1, BClabel=1, BCdata=32'h11, BCsrc=0; BCEN=0 after edge 3.
//   3. Round robin: src0/1/2 push labels 1/2/3 in the same cycle -> broadcasts 1,2,3 on consecutive cycles.
//      Repeat with labels 4/5/6 -> order 4,5,6 (ptr returned to 2).
//   4. Backpressure: all three sources push every cycle for 8 cycles
//      -> src_ready drops when count=DEPTH; no accepted result lost or duplicated;
//         BCsrc strictly cycles 0,1,2.
//   5. Label 0: src1 offers label 0 -> src_ready[1] handshake completes, never broadcast,
//      err_zero_label=1 and stays 1 until nRST.
//   6. Abort: 4 results buffered, nRST pulsed low mid-cycle -> BCEN=0 immediately.
//      After release no stale broadcast occurs; the same scenario with flush=1 gives the same result.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: per-source result FIFOs feeding one registered
// broadcast per cycle, granted round-robin across the functional units.
module cdb_arbiter #(
  parameter int N_SRC   = 3,
  parameter int DEPTH   = 2,
  parameter int LABEL_W = 5,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC*LABEL_W-1:0]   src_label,
  input  logic [N_SRC*DATA_W-1:0]    src_data,
  output logic [N_SRC-1:0]           src_ready,
  output logic                       BCEN,
  output logic [LABEL_W-1:0]         BClabel,
  output logic [DATA_W-1:0]          BCdata,
  output logic [1:0]                 BCsrc,
  output logic                       err_zero_label
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [1:0] RR_INIT = 2'(N_SRC - 1);

  typedef struct packed {
    logic [LABEL_W-1:0] label;
    logic [DATA_W-1:0]  data;
  } entry_t;

  entry_t             mem_q    [N_SRC][DEPTH];
  entry_t             in_entry [N_SRC];
  logic [CNT_W-1:0]   cnt_q [N_SRC], cnt_d [N_SRC];
  logic [PTR_W-1:0]   wr_q  [N_SRC], wr_d  [N_SRC];
  logic [PTR_W-1:0]   rd_q  [N_SRC], rd_d  [N_SRC];

  logic [N_SRC-1:0]   nonempty, store, pop, zero_offer;
  logic [1:0]         win;
  logic               win_vld;
  entry_t             head;

  logic               bcen_q, bcen_d;
  logic [LABEL_W-1:0] label_q, label_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [1:0]         src_q, src_d;
  logic [1:0]         rr_q, rr_d;
  logic               err_q, err_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready depends only on the registered count, so a full FIFO stays
  // not-ready even in the cycle it is being popped.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_ready[i]  = (cnt_q[i] < CNT_W'(DEPTH));
      nonempty[i]   = (cnt_q[i] != '0);
      in_entry[i]   = {src_label[i*LABEL_W +: LABEL_W], src_data[i*DATA_W +: DATA_W]};
      zero_offer[i] = src_valid[i] & src_ready[i] & (in_entry[i].label == '0);
      store[i]      = src_valid[i] & src_ready[i] & ~zero_offer[i] & ~flush;
    end
  end

  // Scan from farthest to nearest so the nearest candidate after rr_q wins.
  always_comb begin
    logic [1:0] idx;
    idx     = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = 2'((int'(rr_q) + k) % N_SRC);
      if (nonempty[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
    pop  = '0;
    head = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (win_vld && !flush && (win == 2'(i))) begin
        pop[i] = 1'b1;
        head   = mem_q[i][rd_q[i]];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      wr_d[i]  = wr_q[i];
      rd_d[i]  = rd_q[i];
      if (flush) begin
        cnt_d[i] = '0;
        wr_d[i]  = '0;
        rd_d[i]  = '0;
      end else begin
        if (store[i]) wr_d[i] = ptr_inc(wr_q[i]);
        if (pop[i])   rd_d[i] = ptr_inc(rd_q[i]);
        case ({store[i], pop[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
          2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
  end

  always_comb begin
    bcen_d  = 1'b0;
    label_d = label_q;
    data_d  = data_q;
    src_d   = src_q;
    rr_d    = rr_q;
    err_d   = err_q | ((|zero_offer) & ~flush);
    if (flush) begin
      rr_d = RR_INIT;
    end else if (win_vld) begin
      bcen_d  = 1'b1;
      label_d = head.label;
      data_d  = head.data;
      src_d   = win;
      rr_d    = win;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < N_SRC; i++) begin
        cnt_q[i] <= '0;
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
      end
      bcen_q  <= 1'b0;
      label_q <= '0;
      data_q  <= '0;
      src_q   <= '0;
      rr_q    <= RR_INIT;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        cnt_q[i] <= cnt_d[i];
        wr_q[i]  <= wr_d[i];
        rd_q[i]  <= rd_d[i];
      end
      bcen_q  <= bcen_d;
      label_q <= label_d;
      data_q  <= data_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; an entry is only read
  // after a push has written it, as tracked by the reset counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (store[i]) mem_q[i][wr_q[i]] <= in_entry[i];
    end
  end

  assign BCEN           = bcen_q;
  assign BClabel        = label_q;
  assign BCdata         = data_q;
  assign BCsrc          = src_q;
  assign err_zero_label = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-level reference model feeds a per-edge
// expectation scoreboard; a negedge monitor compares every bus cycle.
module tb_cdb_arbiter;
  localparam int N     = 3;
  localparam int DEPTH = 2;
  localparam int LW    = 5;
  localparam int DW    = 32;

  logic            clk = 1'b0;
  logic            nRST = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    src_valid = '0;
  logic [N*LW-1:0] src_label = '0;
  logic [N*DW-1:0] src_data = '0;
  logic [N-1:0]    src_ready;
  logic            BCEN;
  logic [LW-1:0]   BClabel;
  logic [DW-1:0]   BCdata;
  logic [1:0]      BCsrc;
  logic            err_zero_label;

  cdb_arbiter #(.N_SRC(N), .DEPTH(DEPTH), .LABEL_W(LW), .DATA_W(DW)) dut (
    .clk(clk), .nRST(nRST), .flush(flush),
    .src_valid(src_valid), .src_label(src_label), .src_data(src_data),
    .src_ready(src_ready), .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata),
    .BCsrc(BCsrc), .err_zero_label(err_zero_label)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LW-1:0] label;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    bit            en;
    logic [LW-1:0] label;
    logic [DW-1:0] data;
    logic [1:0]    src;
  } exp_t;

  ent_t          mq [N][$];
  exp_t          exp_q [$];
  exp_t          mon_e;
  int            m_rr;
  bit            m_err;
  logic [LW-1:0] m_label;
  logic [DW-1:0] m_data;
  logic [1:0]    m_src;
  bit            acc [N];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mq[i].size() < DEPTH);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      acc[i] = 1'b0;
    end
    exp_q.delete();
    m_rr = N - 1; m_err = 1'b0;
    m_label = '0; m_data = '0; m_src = '0;
  endtask

  // What the bus must show after this edge, given the inputs present at it.
  task automatic model_step();
    logic [N-1:0]  rdy;
    exp_t          e;
    ent_t          h;
    int            start, idx;
    logic [LW-1:0] lab;
    rdy = model_ready();
    for (int i = 0; i < N; i++) acc[i] = src_valid[i] && rdy[i];
    e.en = 1'b0;
    if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr = N - 1;
    end else begin
      start = m_rr;
      for (int k = 1; k <= N; k++) begin
        idx = (start + k) % N;
        if (!e.en && mq[idx].size() > 0) begin
          h = mq[idx].pop_front();
          e.en = 1'b1;
          m_label = h.label; m_data = h.data; m_src = 2'(idx); m_rr = idx;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          lab = src_label[i*LW +: LW];
          if (lab == '0) m_err = 1'b1;
          else mq[i].push_back({lab, src_data[i*DW +: DW]});
        end
      end
    end
    e.label = m_label; e.data = m_data; e.src = m_src;
    exp_q.push_back(e);
  endtask

  // One clock: check handshake state, cross the edge, retire accepted offers.
  task automatic step();
    check("src_ready", src_ready, model_ready());
    check("err_zero_label", err_zero_label, m_err);
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) src_valid[i] = 1'b0;
    flush = 1'b0;
  endtask

  task automatic offer(input int i, input int lab, input logic [DW-1:0] d);
    src_valid[i] = 1'b1;
    src_label[i*LW +: LW] = LW'(lab);
    src_data[i*DW +: DW] = d;
  endtask

  always @(negedge clk) begin
    if (nRST) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bcen", BCEN, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("bcen", BCEN, mon_e.en);
        check("bclabel", BClabel, mon_e.label);
        check("bcdata", BCdata, mon_e.data);
        check("bcsrc", BCsrc, mon_e.src);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 nRST = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_bcen", BCEN, 0);
    check("reset_bclabel", BClabel, 0);
    check("reset_bcdata", BCdata, 0);
    check("reset_bcsrc", BCsrc, 0);
    check("reset_src_ready", src_ready, 3'b111);
    check("reset_err", err_zero_label, 0);
    nRST = 1'b1;

    // single result from source 0
    offer(0, 1, 32'h11);
    step();
    repeat (3) step();

    // round robin from the post-flush pointer, twice
    flush = 1'b1;
    step();
    for (int i = 0; i < N; i++) offer(i, i + 1, $urandom);
    step();
    repeat (4) step();
    for (int i = 0; i < N; i++) offer(i, i + 4, $urandom);
    step();
    repeat (4) step();

    // backpressure: every source offers every cycle
    repeat (8) begin
      for (int i = 0; i < N; i++)
        if (!src_valid[i]) offer(i, $urandom_range(1, 31), $urandom);
      step();
    end
    repeat (10) step();

    // label 0 is swallowed and sets the sticky error
    offer(1, 0, $urandom);
    step();
    repeat (4) step();

    // async reset with results buffered
    repeat (2) begin
      for (int i = 0; i < N; i++)
        if (!src_valid[i]) offer(i, $urandom_range(1, 31), $urandom);
      step();
    end
    src_valid = '0;
    #1 nRST = 1'b0;
    #1;
    check("async_reset_bcen", BCEN, 0);
    check("async_reset_err", err_zero_label, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 nRST = 1'b1;
    repeat (5) step();

    // same scenario with flush
    repeat (2) begin
      for (int i = 0; i < N; i++)
        if (!src_valid[i]) offer(i, $urandom_range(1, 31), $urandom);
      step();
    end
    src_valid = '0;
    flush = 1'b1;
    step();
    repeat (5) step();

    // randomized traffic with occasional label 0 and flush
    repeat (400) begin
      for (int i = 0; i < N; i++)
        if (!src_valid[i] && $urandom_range(0, 99) < 60)
          offer(i, ($urandom_range(0, 99) < 5) ? 0 : int'($urandom_range(1, 31)), $urandom);
      flush = ($urandom_range(0, 199) == 0);
      step();
    end
    src_valid = '0;
    repeat (10) step();
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
